// File: rtl/jk_drive_seq.sv
// Sequencing driver for a bank of JK flip-flops: accepts target words, drives one edge of
// excitation codes, then reads the bank back and flags any divergence from the target.
module jk_drive_seq #(
    parameter int unsigned WIDTH       = 4,
    parameter bit          TOGGLE_PREF = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tgt_valid,
    input  logic [WIDTH-1:0]   tgt_data,
    output logic               tgt_ready,
    output logic [2*WIDTH-1:0] jk,
    input  logic [WIDTH-1:0]   q_in,
    output logic [WIDTH-1:0]   cur_q,
    output logic               done,
    output logic               mismatch,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {StInit, StIdle, StDrive, StCheck} state_e;

    // All pairs at 01 keep the bank cleared while reset or INIT is in effect.
    localparam logic [2*WIDTH-1:0] JkClear = {WIDTH{2'b01}};

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   jk_q, jk_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [WIDTH-1:0]     cur_q_q, cur_q_d;
    logic                 rdy_q, rdy_d;
    logic                 done_q, done_d;
    logic                 mism_q, mism_d;
    logic [7:0]           err_q, err_d;
    logic [2*WIDTH-1:0]   code;

    always_comb begin
        code = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({cur_q_q[i], tgt_data[i]})
                2'b01:   code[2*i +: 2] = TOGGLE_PREF ? 2'b11 : 2'b10;
                2'b10:   code[2*i +: 2] = TOGGLE_PREF ? 2'b11 : 2'b01;
                default: code[2*i +: 2] = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        jk_d    = '0;
        exp_d   = exp_q;
        cur_q_d = cur_q_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        mism_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StInit: begin
                exp_d   = '0;
                state_d = StCheck;
            end
            StIdle: begin
                rdy_d = 1'b1;
                if (tgt_valid && rdy_q) begin
                    exp_d   = tgt_data;
                    jk_d    = code;
                    rdy_d   = 1'b0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                state_d = StCheck;
            end
            StCheck: begin
                done_d  = 1'b1;
                mism_d  = (q_in != exp_q);
                cur_q_d = q_in;
                if ((q_in != exp_q) && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            jk_q    <= JkClear;
            exp_q   <= '0;
            cur_q_q <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            mism_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            jk_q    <= jk_d;
            exp_q   <= exp_d;
            cur_q_q <= cur_q_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = rdy_q;
    assign jk        = jk_q;
    assign cur_q     = cur_q_q;
    assign done      = done_q;
    assign mismatch  = mism_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq: two instances (set/reset and toggle preference), each driving a
// behavioural 4-bit JK bank; bank 0 can have bit 2 stuck at 0.
module tb_jk_drive_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tv0 = 1'b0, tv1 = 1'b0;
    logic [3:0] td0 = '0, td1 = '0;
    logic       rdy0, rdy1, done0, done1, mism0, mism1;
    logic [7:0] jk0, jk1, err0, err1;
    logic [3:0] cur0, cur1;
    logic [3:0] bank0, bank1;
    logic       fault0 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jk_drive_seq #(.WIDTH(4), .TOGGLE_PREF(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tv0), .tgt_data(td0), .tgt_ready(rdy0),
        .jk(jk0), .q_in(bank0), .cur_q(cur0), .done(done0), .mismatch(mism0), .err_cnt(err0)
    );

    jk_drive_seq #(.WIDTH(4), .TOGGLE_PREF(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tv1), .tgt_data(td1), .tgt_ready(rdy1),
        .jk(jk1), .q_in(bank1), .cur_q(cur1), .done(done1), .mismatch(mism1), .err_cnt(err1)
    );

    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [7:0] c);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            case ({c[2*i+1], c[2*i]})
                2'b01:   n[i] = 1'b0;
                2'b10:   n[i] = 1'b1;
                2'b11:   n[i] = ~q[i];
                default: n[i] = q[i];
            endcase
        end
        return n;
    endfunction

    initial begin
        bank0 = 4'($urandom);
        bank1 = 4'($urandom);
    end

    always @(posedge clk) begin
        bank0 <= fault0 ? (jk_next(bank0, jk0) & 4'b1011) : jk_next(bank0, jk0);
        bank1 <= jk_next(bank1, jk1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Asserts reset from the current point, checks reset values, then walks the INIT sequence.
    task automatic do_reset();
        logic saw_done;
        rst_n = 1'b0;
        #1;
        check("rst_jk0", 32'(jk0), 32'h55);
        check("rst_jk1", 32'(jk1), 32'h55);
        check("rst_state", {rdy0, done0, mism0, cur0, err0}, 32'h0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw_done |= done0 | done1;
        end
        check("rst_no_done", 32'(saw_done), 32'h0);
        check("rst_bank_cleared", 32'(bank0), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("init_R", {jk0, done0, rdy0}, 32'h0);
        @(posedge clk); #1;
        check("init_R1_0", {done0, mism0, cur0, rdy0}, {1'b1, 1'b0, 4'h0, 1'b1});
        check("init_R1_1", {done1, mism1, cur1, rdy1}, {1'b1, 1'b0, 4'h0, 1'b1});
    endtask

    // Runs one full transaction; returns jk in DRIVE, jk in CHECK and outputs after the check.
    task automatic txn(input bit sel, input logic [3:0] d, output logic [7:0] jk_drv,
                       output logic [7:0] jk_chk, output logic dn, output logic mm,
                       output logic [3:0] cur, output logic [7:0] err);
        int n = 0;
        while (!(sel ? rdy1 : rdy0) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 10) check("ready_timeout", 32'(sel ? rdy1 : rdy0), 32'h1);
        if (sel) begin tv1 = 1'b1; td1 = d; end
        else     begin tv0 = 1'b1; td0 = d; end
        @(posedge clk); #1;
        tv0 = 1'b0;
        tv1 = 1'b0;
        jk_drv = sel ? jk1 : jk0;
        @(posedge clk); #1;
        jk_chk = sel ? jk1 : jk0;
        @(posedge clk); #1;
        dn  = sel ? done1 : done0;
        mm  = sel ? mism1 : mism0;
        cur = sel ? cur1 : cur0;
        err = sel ? err1 : err0;
    endtask

    typedef struct {
        bit         sel;
        logic [3:0] tgt;
        logic [7:0] jk;
    } vec_t;

    vec_t vecs[9];
    logic [3:0] words[5];

    initial begin
        logic [7:0] jd, jc, er;
        logic       dn, mm;
        logic [3:0] cu;

        vecs[0] = '{1'b0, 4'b1010, 8'b10001000};
        vecs[1] = '{1'b0, 4'b0110, 8'b01100000};
        vecs[2] = '{1'b0, 4'b0110, 8'b00000000};
        vecs[3] = '{1'b0, 4'b0001, 8'b00010110};
        vecs[4] = '{1'b0, 4'b1111, 8'b10101000};
        vecs[5] = '{1'b0, 4'b0000, 8'b01010101};
        vecs[6] = '{1'b1, 4'b1111, 8'b11111111};
        vecs[7] = '{1'b1, 4'b1111, 8'b00000000};
        vecs[8] = '{1'b1, 4'b0101, 8'b11001100};

        @(posedge clk); #1;
        do_reset();

        foreach (vecs[i]) begin
            txn(vecs[i].sel, vecs[i].tgt, jd, jc, dn, mm, cu, er);
            check($sformatf("vec%0d_jk", i), 32'(jd), 32'(vecs[i].jk));
            check($sformatf("vec%0d_jk_off", i), 32'(jc), 32'h0);
            check($sformatf("vec%0d_done", i), {dn, mm}, 32'b10);
            check($sformatf("vec%0d_cur", i), 32'(cu), 32'(vecs[i].tgt));
            check($sformatf("vec%0d_err", i), 32'(er), 32'h0);
        end

        // Back-to-back targets with tgt_valid held high.
        begin
            int acc = 0, dones = 0, run = 0, maxrun = 0, last = -1, gap_bad = 0, idx = 0;
            bit pend;
            words = '{4'b0011, 4'b1100, 4'b0101, 4'b1010, 4'b1111};
            @(posedge clk); #1;
            tv0 = 1'b1;
            td0 = words[0];
            for (int c = 0; c < 40 && dones < 5; c++) begin
                pend = 1'b0;
                if (done0) dones++;
                run = (jk0 != 0) ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
                if (rdy0 && tv0) begin
                    if (last >= 0 && c - last != 3) gap_bad++;
                    last = c;
                    acc++;
                    pend = 1'b1;
                end
                @(posedge clk); #1;
                if (pend) begin
                    idx++;
                    if (idx < 5) td0 = words[idx];
                    else tv0 = 1'b0;
                end
            end
            tv0 = 1'b0;
            check("tput_accepts", 32'(acc), 32'd5);
            check("tput_dones", 32'(dones), 32'd5);
            check("tput_spacing", 32'(gap_bad), 32'd0);
            check("tput_jk_window", 32'(maxrun), 32'd1);
            check("tput_cur", 32'(cur0), 32'hF);
        end

        // Stuck-at-0 on bank bit 2.
        txn(1'b0, 4'b0000, jd, jc, dn, mm, cu, er);
        fault0 = 1'b1;
        txn(1'b0, 4'b0100, jd, jc, dn, mm, cu, er);
        check("fault_jk", 32'(jd), 32'b00100000);
        check("fault_done_mism", {dn, mm}, 32'b11);
        check("fault_err1", 32'(er), 32'd1);
        check("fault_cur", 32'(cu), 32'h0);
        for (int k = 0; k < 299; k++) txn(1'b0, 4'b0100, jd, jc, dn, mm, cu, er);
        check("fault_sat_err", 32'(er), 32'd255);
        check("fault_sat_mism", {dn, mm}, 32'b11);
        fault0 = 1'b0;

        // Reset asserted while DRIVE is presenting codes.
        while (!rdy0) begin @(posedge clk); #1; end
        tv0 = 1'b1;
        td0 = 4'b0100;
        @(posedge clk); #1;
        tv0 = 1'b0;
        check("midop_drive_jk", 32'(jk0), 32'b00100000);
        do_reset();
        check("midop_err_clear", 32'(err0), 32'h0);

        txn(1'b0, 4'b1001, jd, jc, dn, mm, cu, er);
        check("post_reset_jk", 32'(jd), 32'b10000010);
        check("post_reset_done", {dn, mm, cu}, {1'b1, 1'b0, 4'b1001});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
